cineraria_gpio_ex: RTL and testbench
====================================

// Module: cineraria_gpio_ex
// PURPOSE
//  Parametrised Avalon-MM GPIO peripheral, next generation of the core GPIO.
//  Adds: configurable width, input synchroniser, atomic set/clear writes,
//  edge capture with per-bit IRQ mask.
//  Sits on the system bus as slave s1; drives board pins through bidir_port.
// PARAMETERS
//  WIDTH        32      number of GPIO bits, 1..32; readdata bits >= WIDTH read 0
//  SYNC_STAGES  2       input synchroniser depth, 2..4
//  EDGE_TYPE    0       capture edge: 0 rising, 1 falling, 2 any
//  RESET_OUT    0       reset value of data_out[WIDTH-1:0]
//  RESET_DIR    0       reset value of data_dir[WIDTH-1:0] (1 = output)
// PORTS
//  clk         in     1      system clock, all state on rising edge
//  reset       in     1      synchronous reset, active-high
//  address     in     3      word register index
//  chipselect  in     1      slave select
//  write_n     in     1      write strobe, active-low, qualified by chipselect
//  writedata   in     32     write data
//  readdata    out    32     registered read data, latency 1
//  irq         out    1      level interrupt, active-high
//  bidir_port  inout  WIDTH  GPIO pins; bit i driven by data_out[i] when data_dir[i]=1, else Z
// BEHAVIOUR
//  - wr = chipselect & ~write_n. Register map (word address):
//    0 DATA     R: data_in (synchronised pins)   W: data_out <= wd
//    1 DIR      R/W data_dir
//    2 IRQMASK  R/W irq_mask
//    3 EDGECAP  R: edge_cap   W: clear bits where wd=1 (W1C)
//    4 OUTSET   R: data_out   W: data_out <= data_out | wd
//    5 OUTCLR   R: data_out   W: data_out <= data_out & ~wd
//    6,7        R: 0          W: ignored
//  - readdata <= mux(address) every cycle; no read strobe; a write's effect is
//    visible in readdata 2 cycles after the write cycle.
//  - Sync: pins pass through SYNC_STAGES flops -> data_in; prev <= data_in.
//    Pin change visible on DATA read after SYNC_STAGES+1 cycles.
//  - Edge detect per bit: rise = data_in & ~prev, fall = ~data_in & prev.
//    Detected edge sets edge_cap[i] the same cycle. Set wins over W1C
//    clear in the same cycle.
//  - Output bits feed back through the pins, so they are captured like inputs.
//  - irq = |(edge_cap & irq_mask), combinational from registers, no glitch source.
//  - Reset (any cycle, incl. mid-transaction): readdata=0, data_out=RESET_OUT,
//    data_dir=RESET_DIR, irq_mask=0, edge_cap=0, sync/prev flops=0, irq=0.
//    No edge is captured in the first cycle after reset deasserts; prev
//    is loaded first.
//  - Unused writedata bits >= WIDTH are ignored.
// CONFIGURATION
//  CINERARIA_GPIO_IRQ_EN defined: edge capture, IRQMASK, EDGECAP and irq as above.
//  Not defined: no edge_cap/irq_mask/prev flops; addresses 2,3 read 0, writes
//  ignored; irq tied 0. The port list is unchanged.
// STRUCTURE
//  Package cineraria_gpio_pkg:
//  - localparams ADDR_DATA..ADDR_OUTCLR (3-bit)
//  - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings
//  Sub-module cineraria_gpio_sync:
//  - WIDTH x SYNC_STAGES flop chain, synchronous reset; instantiated once
//  Top: register file, read mux, edge logic, tristate assigns (generate loop)
// TESTING
//  1 DIR=0x0000_00FF, DATA=0xA5 -> pins[7:0]=0xA5, pins[31:8]=Z; read DATA -> 0xA5 in [7:0]
//  2 data_out=0x0F; OUTSET 0x30 -> 0x3F; OUTCLR 0x05 -> 0x3A; reads at addr 4/5 -> 0x3A
//  3 EDGE_TYPE=0, mask=0x1, drive pin0 0->1 -> EDGECAP=0x1 and irq=1 after
//    SYNC_STAGES+1 cycles; W1C 0x1 -> irq=0 next cycle
//  4 Edge on pin0 in same cycle as W1C 0x1 -> edge_cap[0] stays 1, irq stays 1
//  5 Assert reset mid-write of DIR=0xFFFF -> all regs at RESET_* / 0, pins Z (RESET_DIR=0)
//  6 WIDTH=8, IRQ_EN undefined: write 0xFFFF_FFFF to DIR -> read 0x0000_00FF;
//    addr 3 reads 0, irq=0

Source files
------------

// File: rtl/cineraria_gpio_pkg.sv
// cineraria_gpio_pkg: register map and edge-type encodings shared by the GPIO peripheral.
package cineraria_gpio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/cineraria_gpio_sync.sv
// cineraria_gpio_sync: WIDTH-bit, STAGES-deep synchroniser chain for asynchronous pin inputs.
module cineraria_gpio_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '{default: '0};
        end else begin
            chain[0] <= d;
            for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cineraria_gpio_ex.sv
// cineraria_gpio_ex: Avalon-MM GPIO with pin synchroniser, atomic set/clear and edge-capture IRQ.
// Edge capture, IRQMASK/EDGECAP registers and irq exist only when CINERARIA_GPIO_IRQ_EN is defined.
module cineraria_gpio_ex
    import cineraria_gpio_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int          EDGE_TYPE   = 0,
    parameter logic [31:0] RESET_OUT   = 32'h0,
    parameter logic [31:0] RESET_DIR   = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    inout  wire  [WIDTH-1:0] bidir_port
);

    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        (EDGE_TYPE != EDGE_RISE && EDGE_TYPE != EDGE_FALL && EDGE_TYPE != EDGE_ANY)) begin : g_bad_param
        $error("cineraria_gpio_ex: parameter out of range");
    end

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] out_nxt;
    logic [WIDTH-1:0] data_dir;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [31:0]      rd_mux;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    // Pins are sampled after the tristate drivers, so driven outputs read back like inputs.
    cineraria_gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bidir_port),
        .q     (data_in)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign bidir_port[i] = data_dir[i] ? data_out[i] : 1'bz;
    end

    assign out_nxt = !wr                     ? data_out :
                     address == ADDR_DATA    ? wd :
                     address == ADDR_OUTSET  ? data_out | wd :
                     address == ADDR_OUTCLR  ? data_out & ~wd : data_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= RESET_OUT[WIDTH-1:0];
            data_dir <= RESET_DIR[WIDTH-1:0];
        end else begin
            data_out <= out_nxt;
            if (wr && address == ADDR_DIR) data_dir <= wd;
        end
    end

`ifdef CINERARIA_GPIO_IRQ_EN
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] cap_kept;

    // prev resets to the same value as data_in, so nothing fires the cycle after reset.
    assign hit = EDGE_TYPE == EDGE_RISE ? data_in & ~prev :
                 EDGE_TYPE == EDGE_FALL ? ~data_in & prev : data_in ^ prev;
    assign cap_kept = wr && address == ADDR_EDGECAP ? edge_cap & ~wd : edge_cap;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev     <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            prev     <= data_in;
            edge_cap <= cap_kept | hit;
            if (wr && address == ADDR_IRQMASK) irq_mask <= wd;
        end
    end

    assign irq = |(edge_cap & irq_mask);
`else
    assign irq_mask = '0;
    assign edge_cap = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux = 32'(data_in);
            ADDR_DIR:     rd_mux = 32'(data_dir);
            ADDR_IRQMASK: rd_mux = 32'(irq_mask);
            ADDR_EDGECAP: rd_mux = 32'(edge_cap);
            ADDR_OUTSET:  rd_mux = 32'(data_out);
            ADDR_OUTCLR:  rd_mux = 32'(data_out);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_mux;
    end

endmodule

// File: tb/tb_cineraria_gpio_ex.sv
// tb_cineraria_gpio_ex: directed and random checks of the GPIO against a cycle-level reference model.
module tb_cineraria_gpio_ex;

    localparam int          W     = 12;
    localparam int          S     = 3;
    localparam int          ET    = 0;
    localparam logic [31:0] R_OUT = 32'h5C3;
    localparam logic [31:0] R_DIR = 32'h0;
`ifdef CINERARIA_GPIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   address = '0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = '0;
    logic [31:0]  readdata;
    logic         irq;
    wire  [W-1:0] pins;
    logic [W-1:0] tb_val = '0;
    logic [W-1:0] tb_oe = '0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < W; i++) begin : g_drv
        assign pins[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    cineraria_gpio_ex #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .EDGE_TYPE   (ET),
        .RESET_OUT   (R_OUT),
        .RESET_DIR   (R_DIR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .bidir_port (pins)
    );

    // Reference model: register contents plus a history of pin values seen at each clock edge.
    logic [W-1:0] m_out = R_OUT[W-1:0];
    logic [W-1:0] m_dir = R_DIR[W-1:0];
    logic [W-1:0] m_mask = '0;
    logic [W-1:0] m_cap = '0;
    logic [W-1:0] hist[$];
    int           total = 0;
    int           passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc(input logic [2:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd, input logic rst);
        logic [W-1:0] pin, din, prv, ev, wdw;
        logic [31:0]  rd;
        logic         w;
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        reset      = rst;
        w   = cs & ~wn;
        wdw = wd[W-1:0];
        pin = (m_dir & m_out) | (~m_dir & tb_val);
        din = hist[S-1];
        prv = hist[S];
        ev  = ET == 0 ? din & ~prv : ET == 1 ? ~din & prv : din ^ prv;
        case (a)
            3'd0:       rd = 32'(din);
            3'd1:       rd = 32'(m_dir);
            3'd2:       rd = 32'(m_mask);
            3'd3:       rd = 32'(m_cap);
            3'd4, 3'd5: rd = 32'(m_out);
            default:    rd = 32'h0;
        endcase
        @(posedge clk);
        #1;
        if (rst) begin
            rd     = 32'h0;
            m_out  = R_OUT[W-1:0];
            m_dir  = R_DIR[W-1:0];
            m_mask = '0;
            m_cap  = '0;
            foreach (hist[k]) hist[k] = '0;
        end else begin
            if (w) begin
                case (a)
                    3'd0: m_out = wdw;
                    3'd1: m_dir = wdw;
                    3'd2: if (IRQ_EN) m_mask = wdw;
                    3'd3: m_cap = m_cap & ~wdw;
                    3'd4: m_out = m_out | wdw;
                    3'd5: m_out = m_out & ~wdw;
                    default: ;
                endcase
            end
            if (IRQ_EN) m_cap = m_cap | ev;
            hist.push_front(pin);
            void'(hist.pop_back());
        end
        chk("readdata", readdata, rd);
        chk("irq", 32'(irq), 32'(|(m_cap & m_mask)));
        tb_oe = ~m_dir;
    endtask

    initial begin
        for (int k = 0; k <= S; k++) hist.push_back('0);
        cyc(3'd0, 1'b0, 1'b1, 32'h0, 1'b1);
        cyc(3'd0, 1'b0, 1'b1, 32'h0, 1'b1);
        chk("rst_irq", 32'(irq), 32'h0);

        // Low byte as outputs, pattern on the pins and back through DATA.
        cyc(3'd1, 1'b1, 1'b0, 32'h0000_00FF, 1'b0);
        cyc(3'd0, 1'b1, 1'b0, 32'h0000_00A5, 1'b0);
        chk("pins_out", 32'(pins[7:0]), 32'hA5);
        repeat (S + 1) cyc(3'd0, 1'b1, 1'b1, 32'h0, 1'b0);
        chk("data_rd", readdata & 32'hFF, 32'hA5);

        // Atomic set/clear.
        cyc(3'd0, 1'b1, 1'b0, 32'h0F, 1'b0);
        cyc(3'd4, 1'b1, 1'b0, 32'h30, 1'b0);
        cyc(3'd5, 1'b1, 1'b0, 32'h05, 1'b0);
        cyc(3'd4, 1'b1, 1'b1, 32'h0, 1'b0);
        chk("outset_rd", readdata, 32'h3A);
        cyc(3'd5, 1'b1, 1'b1, 32'h0, 1'b0);
        chk("outclr_rd", readdata, 32'h3A);

`ifdef CINERARIA_GPIO_IRQ_EN
        // Rising edge on pin0 raises irq; W1C drops it; an edge coincident with W1C wins.
        tb_val = '0;
        cyc(3'd1, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(3'd2, 1'b1, 1'b0, 32'h1, 1'b0);
        repeat (S + 3) cyc(3'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        chk("irq_idle", 32'(irq), 32'h0);
        tb_val = 12'h001;
        repeat (S) cyc(3'd3, 1'b1, 1'b1, 32'h0, 1'b0);
        chk("irq_early", 32'(irq), 32'h0);
        cyc(3'd3, 1'b1, 1'b1, 32'h0, 1'b0);
        chk("irq_set", 32'(irq), 32'h1);
        cyc(3'd3, 1'b1, 1'b0, 32'h1, 1'b0);
        chk("edgecap_rd", readdata, 32'h1);
        chk("irq_w1c", 32'(irq), 32'h0);
        tb_val = '0;
        repeat (S + 2) cyc(3'd3, 1'b1, 1'b0, 32'h1, 1'b0);
        tb_val = 12'h001;
        repeat (S + 1) cyc(3'd3, 1'b1, 1'b0, 32'h1, 1'b0);
        chk("set_wins", 32'(irq), 32'h1);
        cyc(3'd3, 1'b1, 1'b0, 32'h1, 1'b0);
        chk("irq_clr2", 32'(irq), 32'h0);
`endif

        // Reset arriving during a DIR write.
        cyc(3'd0, 1'b1, 1'b0, 32'hFFF, 1'b0);
        cyc(3'd2, 1'b1, 1'b0, 32'hFFF, 1'b0);
        cyc(3'd1, 1'b1, 1'b0, 32'hFFFF, 1'b1);
        chk("rst_rd", readdata, 32'h0);
        chk("rst_irq2", 32'(irq), 32'h0);
        cyc(3'd1, 1'b1, 1'b1, 32'h0, 1'b0);
        chk("dir_rst", readdata, 32'h0);
        cyc(3'd4, 1'b1, 1'b1, 32'h0, 1'b0);
        chk("out_rst", readdata, R_OUT & 32'hFFF);
        cyc(3'd2, 1'b1, 1'b1, 32'h0, 1'b0);
        chk("mask_rst", readdata, 32'h0);

        // Writedata bits beyond WIDTH, unselected write, unused addresses.
        cyc(3'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        cyc(3'd1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("dir_wide", readdata, 32'hFFF);
        cyc(3'd1, 1'b1, 1'b1, 32'h0, 1'b0);
        chk("cs_gate", readdata, 32'hFFF);
        cyc(3'd6, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        cyc(3'd7, 1'b1, 1'b1, 32'h0, 1'b0);
        chk("addr6_rd", readdata, 32'h0);

        for (int n = 0; n < 400; n++) begin
            tb_val = W'($urandom);
            cyc(3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, 1'($urandom),
                $urandom, $urandom_range(0, 49) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
